instr_fetch: RTL and testbench

Instruction fetch stage for the RV32I core: owns the program counter, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned words in a 2-entry queue. It presents one instruction at a time, with its PC, to the control unit and decode logic. It consumes the control unit's `PCSrc` and the immediate `ImmOp` to redirect fetch on taken branches, discarding any wrong-path words.

---
 rtl/instr_fetch.sv | 156 +++++++++++++++
 tb/tb_instr_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// RV32I instruction fetch stage: owns the PC, issues word requests over a req/gnt/rvalid
// handshake, queues returned words with their PCs, and redirects on taken branches.

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        PCSrc,
    input  logic [31:0] ImmOp
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] base, input logic [CW-1:0] off);
        int sum;
        sum = int'(base) + int'(off);
        if (sum >= DEPTH) begin
            sum = sum - DEPTH;
        end
        return PW'(sum);
    endfunction

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   q_instr_q [DEPTH];
    logic [31:0]   q_instr_d [DEPTH];
    logic [31:0]   q_pc_q    [DEPTH];
    logic [31:0]   q_pc_d    [DEPTH];
    logic [31:0]   pf_pc_q   [DEPTH];
    logic [31:0]   pf_pc_d   [DEPTH];
    logic [PW-1:0] q_head_q, q_head_d;
    logic [PW-1:0] pf_head_q, pf_head_d;
    logic [CW-1:0] q_count_q, q_count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;

    logic          valid_s, pop_s, redirect_s, req_s, grant_s, rsp_s, accept_s;
    logic [SW-1:0] used_s;
    logic [PW-1:0] q_tail_s, pf_tail_s;

    // Handshake decode; the slot freed by a same-cycle pop is reusable so L=1 streams at full rate.
    always_comb begin
        valid_s    = (q_count_q != CNT_ZERO);
        pop_s      = valid_s && instr_ready_i;
        redirect_s = pop_s && PCSrc;
        used_s     = SW'(q_count_q) + SW'(outst_q) - SW'(pop_s);
        req_s      = !rst && !redirect_s && (used_s < SW'(DEPTH));
        grant_s    = req_s && mem_gnt_i;
        rsp_s      = mem_rvalid_i && (outst_q != CNT_ZERO);
        accept_s   = rsp_s && (discard_q == CNT_ZERO) && !redirect_s;
        q_tail_s   = ptr_add(q_head_q, q_count_q);
        pf_tail_s  = ptr_add(pf_head_q, outst_q);
    end

    // Next-state for PC, in-flight tracking and the instruction queue.
    always_comb begin
        q_instr_d = q_instr_q;
        q_pc_d    = q_pc_q;
        pf_pc_d   = pf_pc_q;

        if (redirect_s) begin
            fetch_pc_d = (pc_o + ImmOp) & 32'hFFFF_FFFC;
        end else if (grant_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        if (grant_s) begin
            pf_pc_d[pf_tail_s] = fetch_pc_q;
        end else begin
            pf_pc_d = pf_pc_q;
        end
        if (rsp_s) begin
            pf_head_d = ptr_add(pf_head_q, CNT_ONE);
        end else begin
            pf_head_d = pf_head_q;
        end
        outst_d = outst_q + (grant_s ? CNT_ONE : CNT_ZERO) - (rsp_s ? CNT_ONE : CNT_ZERO);

        // A response landing in the redirect cycle is dropped here, not counted as discard.
        if (redirect_s) begin
            discard_d = outst_q - (rsp_s ? CNT_ONE : CNT_ZERO);
        end else if (rsp_s && (discard_q != CNT_ZERO)) begin
            discard_d = discard_q - CNT_ONE;
        end else begin
            discard_d = discard_q;
        end

        if (redirect_s) begin
            q_head_d  = q_head_q;
            q_count_d = CNT_ZERO;
        end else begin
            if (accept_s) begin
                q_instr_d[q_tail_s] = mem_rdata_i;
                q_pc_d[q_tail_s]    = pf_pc_q[pf_head_q];
            end else begin
                q_instr_d = q_instr_q;
            end
            if (pop_s) begin
                q_head_d = ptr_add(q_head_q, CNT_ONE);
            end else begin
                q_head_d = q_head_q;
            end
            q_count_d = q_count_q + (accept_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
            q_head_q   <= {PW{1'b0}};
            pf_head_q  <= {PW{1'b0}};
            q_count_q  <= CNT_ZERO;
            outst_q    <= CNT_ZERO;
            discard_q  <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr_q[i] <= 32'h0000_0000;
                q_pc_q[i]    <= 32'h0000_0000;
                pf_pc_q[i]   <= 32'h0000_0000;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            q_head_q   <= q_head_d;
            pf_head_q  <= pf_head_d;
            q_count_q  <= q_count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            q_instr_q  <= q_instr_d;
            q_pc_q     <= q_pc_d;
            pf_pc_q    <= pf_pc_d;
        end
    end

    assign mem_req_o     = req_s;
    assign mem_addr_o    = fetch_pc_q;
    assign instr_valid_o = valid_s;
    assign instr_o       = q_instr_q[q_head_q];
    assign pc_o          = q_pc_q[q_head_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fixed-latency in-order instruction memory whose
// word at address A reads as A ^ 32'hA500_0000.

module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        PCSrc;
    logic [31:0] ImmOp;

    int checks   = 0;
    int failures = 0;
    int lat      = 1;

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .PCSrc        (PCSrc),
        .ImmOp        (ImmOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: grants seen mid-cycle, response driven lat cycles later.
    initial begin
        logic [31:0] pend_addr[$];
        int          pend_due[$];
        int          mcyc;
        mcyc = 0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        forever begin
            @(posedge clk); #1;
            mcyc++;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = 32'h0;
            end else if (pend_due.size() > 0 && pend_due[0] == mcyc) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pend_addr[0] ^ 32'hA500_0000;
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = 32'h0;
            end
            @(negedge clk);
            if (!rst && mem_req_o && mem_gnt_i) begin
                pend_addr.push_back(mem_addr_o);
                pend_due.push_back(mcyc + lat);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int l, input logic rdy, input logic g);
        step();
        rst = 1'b1;
        lat = l;
        instr_ready_i = rdy;
        mem_gnt_i = g;
        PCSrc = 1'b0;
        ImmOp = 32'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req actual=%h required=%h", mem_req_o, 1'b0); end
        checks++; if (mem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr actual=%h required=%h", mem_addr_o, 32'h0); end
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%h required=%h", instr_valid_o, 1'b0); end
        checks++; if (instr_o !== 32'h0) begin failures++; $display("FAIL rst_instr actual=%h required=%h", instr_o, 32'h0); end
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL rst_pc actual=%h required=%h", pc_o, 32'h0); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset(1, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL stream_c0_req actual=%h required=%h", mem_req_o, 1'b1); end
        checks++; if (mem_addr_o !== 32'h0) begin failures++; $display("FAIL stream_c0_addr actual=%h required=%h", mem_addr_o, 32'h0); end
        step(); @(negedge clk);
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL stream_c1_valid actual=%h required=%h", instr_valid_o, 1'b0); end
        checks++; if (mem_addr_o !== 32'h4) begin failures++; $display("FAIL stream_c1_addr actual=%h required=%h", mem_addr_o, 32'h4); end
        for (int i = 0; i < 6; i++) begin
            step(); @(negedge clk);
            e = 32'(i) * 32'd4;
            checks++; if (instr_valid_o !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] actual=%h required=%h", i, instr_valid_o, 1'b1); end
            checks++; if (pc_o !== e) begin failures++; $display("FAIL stream_pc[%0d] actual=%h required=%h", i, pc_o, e); end
            checks++; if (instr_o !== (e ^ 32'hA500_0000)) begin failures++; $display("FAIL stream_instr[%0d] actual=%h required=%h", i, instr_o, e ^ 32'hA500_0000); end
            checks++; if (mem_addr_o !== e + 32'd8) begin failures++; $display("FAIL stream_addr[%0d] actual=%h required=%h", i, mem_addr_o, e + 32'd8); end
        end
    endtask

    task automatic test_ready_stall();
        int gcount;
        gcount = 0;
        do_reset(1, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            @(negedge clk);
            if (mem_req_o && mem_gnt_i) gcount++;
            if (c >= 2) begin
                checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL stall_req[%0d] actual=%h required=%h", c, mem_req_o, 1'b0); end
                checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL stall_pc[%0d] actual=%h required=%h", c, pc_o, 32'h0); end
                checks++; if (instr_o !== 32'hA500_0000) begin failures++; $display("FAIL stall_instr[%0d] actual=%h required=%h", c, instr_o, 32'hA500_0000); end
            end
        end
        checks++; if (gcount !== 2) begin failures++; $display("FAIL stall_grants actual=%0d required=%0d", gcount, 2); end
        checks++; if (mem_addr_o !== 32'h8) begin failures++; $display("FAIL stall_addr actual=%h required=%h", mem_addr_o, 32'h8); end
        step(); instr_ready_i = 1'b1; @(negedge clk);
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL drain_pc0 actual=%h required=%h", pc_o, 32'h0); end
        checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL drain_req actual=%h required=%h", mem_req_o, 1'b1); end
        step(); @(negedge clk);
        checks++; if (pc_o !== 32'h4 || instr_o !== 32'hA500_0004) begin failures++; $display("FAIL drain_pc4 actual=%h/%h required=%h/%h", pc_o, instr_o, 32'h4, 32'hA500_0004); end
        step(); @(negedge clk);
        checks++; if (pc_o !== 32'h8 || instr_valid_o !== 1'b1) begin failures++; $display("FAIL drain_pc8 actual=%h/%h required=%h/%h", pc_o, instr_valid_o, 32'h8, 1'b1); end
    endtask

    task automatic test_branch_discard();
        do_reset(2, 1'b1, 1'b1);
        step(); step(); step(); @(negedge clk);
        checks++; if (pc_o !== 32'h0 || instr_valid_o !== 1'b1) begin failures++; $display("FAIL br_c3_pc actual=%h/%h required=%h/%h", pc_o, instr_valid_o, 32'h0, 1'b1); end
        step(); mem_gnt_i = 1'b0; @(negedge clk);
        checks++; if (pc_o !== 32'h4) begin failures++; $display("FAIL br_c4_pc actual=%h required=%h", pc_o, 32'h4); end
        checks++; if (mem_addr_o !== 32'hC) begin failures++; $display("FAIL br_c4_addr actual=%h required=%h", mem_addr_o, 32'hC); end
        step(); mem_gnt_i = 1'b1; @(negedge clk);
        checks++; if (instr_valid_o !== 1'b0 || mem_addr_o !== 32'hC) begin failures++; $display("FAIL br_c5 actual=%h/%h required=%h/%h", instr_valid_o, mem_addr_o, 1'b0, 32'hC); end
        step(); PCSrc = 1'b1; ImmOp = 32'hFFFF_FFF8; @(negedge clk);
        checks++; if (pc_o !== 32'h8 || instr_valid_o !== 1'b1) begin failures++; $display("FAIL br_c6_pc actual=%h/%h required=%h/%h", pc_o, instr_valid_o, 32'h8, 1'b1); end
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL br_c6_req actual=%h required=%h", mem_req_o, 1'b0); end
        step(); PCSrc = 1'b0; ImmOp = 32'h0; @(negedge clk);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin failures++; $display("FAIL br_c7_target actual=%h/%h required=%h/%h", mem_req_o, mem_addr_o, 1'b1, 32'h0); end
        step(); @(negedge clk);
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL br_c8_dropped actual=%h required=%h", instr_valid_o, 1'b0); end
        step(); @(negedge clk);
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL br_c9_valid actual=%h required=%h", instr_valid_o, 1'b0); end
        step(); @(negedge clk);
        checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'hA500_0000) begin failures++; $display("FAIL br_c10_target actual=%h/%h/%h required=%h/%h/%h", instr_valid_o, pc_o, instr_o, 1'b1, 32'h0, 32'hA500_0000); end
    endtask

    task automatic test_same_cycle_misaligned();
        do_reset(1, 1'b1, 1'b1);
        step(); step(); PCSrc = 1'b1; ImmOp = 32'h0000_0100; @(negedge clk);
        checks++; if (pc_o !== 32'h0 || mem_rvalid_i !== 1'b1) begin failures++; $display("FAIL sc_c2_setup actual=%h/%h required=%h/%h", pc_o, mem_rvalid_i, 32'h0, 1'b1); end
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL sc_c2_req actual=%h required=%h", mem_req_o, 1'b0); end
        step(); PCSrc = 1'b0; ImmOp = 32'h0; @(negedge clk);
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL sc_c3_valid actual=%h required=%h", instr_valid_o, 1'b0); end
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin failures++; $display("FAIL sc_c3_addr actual=%h/%h required=%h/%h", mem_req_o, mem_addr_o, 1'b1, 32'h100); end
        step(); @(negedge clk);
        checks++; if (instr_valid_o !== 1'b0 || mem_addr_o !== 32'h104) begin failures++; $display("FAIL sc_c4 actual=%h/%h required=%h/%h", instr_valid_o, mem_addr_o, 1'b0, 32'h104); end
        step(); PCSrc = 1'b1; ImmOp = 32'h0000_07FE; @(negedge clk);
        checks++; if (pc_o !== 32'h100 || instr_o !== 32'hA500_0100) begin failures++; $display("FAIL sc_c5_head actual=%h/%h required=%h/%h", pc_o, instr_o, 32'h100, 32'hA500_0100); end
        step(); PCSrc = 1'b0; ImmOp = 32'h0; @(negedge clk);
        checks++; if (mem_addr_o !== 32'h8FC || mem_req_o !== 1'b1) begin failures++; $display("FAIL mis_addr actual=%h/%h required=%h/%h", mem_addr_o, mem_req_o, 32'h8FC, 1'b1); end
        step(); @(negedge clk);
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL mis_c7_valid actual=%h required=%h", instr_valid_o, 1'b0); end
        step(); @(negedge clk);
        checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h8FC || instr_o !== 32'hA500_08FC) begin failures++; $display("FAIL mis_c8_head actual=%h/%h/%h required=%h/%h/%h", instr_valid_o, pc_o, instr_o, 1'b1, 32'h8FC, 32'hA500_08FC); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset(1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin failures++; $display("FAIL ms_c0 actual=%h/%h required=%h/%h", mem_req_o, mem_addr_o, 1'b1, 32'h0); end
        step(); mem_gnt_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) step();
            @(negedge clk);
            checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin failures++; $display("FAIL ms_hold[%0d] actual=%h/%h required=%h/%h", c, mem_req_o, mem_addr_o, 1'b1, 32'h4); end
        end
        checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'hA500_0000) begin failures++; $display("FAIL ms_head actual=%h/%h required=%h/%h", instr_valid_o, instr_o, 1'b1, 32'hA500_0000); end
        #1 rst = 1'b1;
        #1;
        checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin failures++; $display("FAIL ms_rst_req actual=%h/%h required=%h/%h", mem_req_o, mem_addr_o, 1'b0, 32'h0); end
        checks++; if (instr_valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0) begin failures++; $display("FAIL ms_rst_out actual=%h/%h/%h required=%h/%h/%h", instr_valid_o, instr_o, pc_o, 1'b0, 32'h0, 32'h0); end
        step(); step(); rst = 1'b0; mem_gnt_i = 1'b1; instr_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin failures++; $display("FAIL ms_restart actual=%h/%h required=%h/%h", mem_req_o, mem_addr_o, 1'b1, 32'h0); end
        step(); step(); @(negedge clk);
        checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'hA500_0000) begin failures++; $display("FAIL ms_first actual=%h/%h/%h required=%h/%h/%h", instr_valid_o, pc_o, instr_o, 1'b1, 32'h0, 32'hA500_0000); end
    endtask

    initial begin
        rst = 1'b1;
        mem_gnt_i = 1'b1;
        instr_ready_i = 1'b1;
        PCSrc = 1'b0;
        ImmOp = 32'h0;
        test_reset();
        test_stream();
        test_ready_stall();
        test_branch_discard();
        test_same_cycle_misaligned();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
